// File: rtl/bcd_display_mux_if.sv
// rtl/bcd_display_mux_if.sv - value/select inputs and seven-segment outputs of the BCD display back end
//
// Purpose: groups the operand, select and display signals of bcd_display_mux
// into one bundle so the producer side and the display side share a single port.
//
// Signals:
//   number_1  [13:0]  unsigned binary value A
//   number_2  [13:0]  unsigned binary value B
//   sel               0 = show number_1, 1 = show number_2
//   an        [3:0]   digit enables, active-low, an[0] = ones digit
//   seg       [6:0]   segments {g,f,e,d,c,b,a}, active-low
//   dp                decimal point, active-low (overflow flag)
//
// Modports:
//   master  drives the values and select, observes the display
//   slave   the display back end itself
interface bcd_display_mux_if;
  logic [13:0] number_1;
  logic [13:0] number_2;
  logic        sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output number_1,
    output number_2,
    output sel,
    input  an,
    input  seg,
    input  dp
  );

  modport slave (
    input  number_1,
    input  number_2,
    input  sel,
    output an,
    output seg,
    output dp
  );
endinterface

// File: rtl/bcd_display_mux.sv
// rtl/bcd_display_mux.sv - select, binary-to-BCD convert and scan a 4-digit seven-segment display
//
// Purpose: picks number_1 or number_2, clamps it to 9999, converts it to four
// BCD digits with a sequential double-dabble engine (1 LOAD + 14 SHIFT +
// 1 COMMIT cycles) and time-multiplexes the digits onto a common-anode
// display. A clamped value lights the decimal point on the ones digit.
//
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (>= 16, so a conversion always
//                fits inside one frame)
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   disp   bcd_display_mux_if.slave: number_1, number_2, sel in; an, seg, dp out
//
// Optional feature macro:
//   BCD_LZ_BLANK_EN  when defined, leading zero digits 3..1 are blanked;
//                    digit 0 is always shown.
module bcd_display_mux #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_display_mux_if.slave  disp
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [13:0] MAX_VAL = 14'd9999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       idx;
  logic             start_pend;

  logic [13:0]      raw;
  logic [13:0]      v;
  logic [15:0]      bcd;
  logic [15:0]      bcd_adj;
  logic             ovf;
  logic [3:0]       bit_cnt;
  logic [15:0]      bcd_q;
  logic             ovf_q;

  logic [3:0]       nib;
  logic             blank;
  logic [6:0]       seg_dec;

  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;

  // ---------------------------------------------------------------------
  // Refresh divider and digit index
  // ---------------------------------------------------------------------
  assign tick = (div_cnt == DIV_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // A frame ends on the tick of digit 3; the request is held until LOAD
  // consumes it. Setting wins over clearing so a request that lands in the
  // LOAD cycle itself is not dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_pend <= 1'b1;
    end else if (tick && (idx == 2'd3)) begin
      start_pend <= 1'b1;
    end else if (state == LOAD) begin
      start_pend <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Converter FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_pend) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 4'd0) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Double-dabble datapath
  // ---------------------------------------------------------------------
  assign raw = disp.sel ? disp.number_2 : disp.number_1;

  // Pre-shift correction: any nibble >= 5 would become >= 10 after the
  // shift, so adding 3 first makes the carry land in the next digit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v       <= '0;
      bcd     <= '0;
      ovf     <= 1'b0;
      bit_cnt <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          v       <= (raw > MAX_VAL) ? MAX_VAL : raw;
          ovf     <= (raw > MAX_VAL);
          bcd     <= '0;
          bit_cnt <= 4'd13;
        end
        SHIFT: begin
          {bcd, v} <= {bcd_adj, v} << 1;
          bit_cnt  <= bit_cnt - 4'd1;
        end
        COMMIT: begin
          bcd_q <= bcd;
          ovf_q <= ovf;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Scan output stage
  // ---------------------------------------------------------------------
  always_comb begin
    nib = 4'd0;
    case (idx)
      2'd0: nib = bcd_q[3:0];
      2'd1: nib = bcd_q[7:4];
      2'd2: nib = bcd_q[11:8];
      2'd3: nib = bcd_q[15:12];
      default: nib = 4'd0;
    endcase
  end

  always_comb begin
    blank = 1'b0;
`ifdef BCD_LZ_BLANK_EN
    // A digit is a leading zero when it and every more significant digit
    // are zero; the ones digit is never blanked so 0 still reads "0".
    case (idx)
      2'd3:    blank = (bcd_q[15:12] == 4'd0);
      2'd2:    blank = (bcd_q[15:8] == 8'd0);
      2'd1:    blank = (bcd_q[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
  end

  always_comb begin
    seg_dec = 7'b1111111;
    case (nib)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b1111111;
    endcase
  end

  // The display register loads only on a tick, so the outputs remain blank
  // after reset until the first slot boundary, and each digit then holds
  // for exactly REFRESH_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
      dp_q  <= 1'b1;
    end else if (tick) begin
      an_q  <= ~(4'b0001 << idx);
      seg_q <= blank ? 7'b1111111 : seg_dec;
      dp_q  <= ~((idx == 2'd0) && ovf_q);
    end
  end

  assign disp.an  = an_q;
  assign disp.seg = seg_q;
  assign disp.dp  = dp_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// tb/tb_bcd_display_mux.sv - randomized self-checking bench for bcd_display_mux
module tb_bcd_display_mux;
  localparam int R = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_on = 1'b0;

  bcd_display_mux_if ifc();

  bcd_display_mux #(.REFRESH_DIV(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .disp  (ifc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: timeline in edges since reset release, values in decimal.
  int         n = 0;
  int         committed = 0;
  bit         c_ovf = 1'b0;
  int         pend = 0;
  bit         p_ovf = 1'b0;
  int         m_raw;
  int         m_d;
  int         m_digit;
  logic [3:0] m_an = 4'hf;
  logic [6:0] m_seg = 7'h7f;
  logic       m_dp = 1'b1;

  function automatic int pow10(input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [15:0] bcd_of(input int val);
    logic [15:0] r = 16'h0;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((val / pow10(i)) % 10);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; committed = 0; c_ovf = 1'b0; pend = 0; p_ovf = 1'b0;
      m_an = 4'hf; m_seg = 7'h7f; m_dp = 1'b1;
    end else begin
      n++;
      // Slot boundary: show the digit of the slot that just ended, using
      // the value committed before this edge.
      if (n % R == 0) begin
        m_d = ((n / R) - 1) % 4;
        m_digit = (committed / pow10(m_d)) % 10;
        m_an = ~(4'b0001 << m_d);
        m_seg = seg_of(m_digit);
`ifdef BCD_LZ_BLANK_EN
        if (m_d > 0 && committed < pow10(m_d)) m_seg = 7'b1111111;
`endif
        m_dp = !(m_d == 0 && c_ovf);
      end
      // Capture in LOAD: second edge after release, then each frame.
      if (n >= 2 && (n - 2) % (4 * R) == 0) begin
        m_raw = ifc.sel ? int'(ifc.number_2) : int'(ifc.number_1);
        p_ovf = (m_raw > 9999);
        pend = p_ovf ? 9999 : m_raw;
      end
      // Commit 15 edges after capture.
      if (n >= 17 && (n - 17) % (4 * R) == 0) begin
        committed = pend;
        c_ovf = p_ovf;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("an", 32'(ifc.an), 32'(m_an));
      chk("seg", 32'(ifc.seg), 32'(m_seg));
      chk("dp", 32'(ifc.dp), 32'(m_dp));
      chk("bcd_q", 32'(dut.bcd_q), 32'(bcd_of(committed)));
      chk("ovf_q", 32'(dut.ovf_q), 32'(c_ovf));
    end
  end

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", 32'(ifc.an), 32'h0000000f);
    chk("async_seg", 32'(ifc.seg), 32'h0000007f);
    chk("async_dp", 32'(ifc.dp), 32'h00000001);
    repeat (cycles) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic run_frames(input int f);
    repeat (f * 4 * R) @(negedge clk);
  endtask

  function automatic logic [13:0] pick();
    case ($urandom_range(0, 7))
      0: return 14'd0;
      1: return 14'd9;
      2: return 14'd99;
      3: return 14'd999;
      4: return 14'd9999;
      5: return 14'd10000;
      6: return 14'd16383;
      default: return 14'($urandom_range(0, 16383));
    endcase
  endfunction

  initial begin
    ifc.number_1 = 14'd1234;
    ifc.number_2 = 14'd0;
    ifc.sel = 1'b0;
    repeat (2) @(posedge clk);
    chk_on = 1'b1;

    // Basic display of 1234.
    do_reset(1);
    run_frames(3);

    // Clamp with overflow flag, reset mid-frame.
    @(negedge clk);
    ifc.number_2 = 14'd16383;
    ifc.sel = 1'b1;
    run_frames(1);
    repeat (R + 5) @(negedge clk);
    do_reset(2);
    run_frames(3);

    // Input change during SHIFT only takes effect next frame.
    @(negedge clk);
    ifc.number_1 = 14'd5;
    ifc.sel = 1'b0;
    do_reset(1);
    repeat (6) @(negedge clk);
    ifc.number_1 = 14'd42;
    run_frames(3);

    // Leading zeros.
    @(negedge clk);
    ifc.number_1 = 14'd7;
    do_reset(1);
    run_frames(2);

    // One-cycle reset pulse during SHIFT.
    @(negedge clk);
    ifc.number_1 = 14'd8765;
    do_reset(1);
    repeat (8) @(posedge clk);
    do_reset(1);
    run_frames(2);

    // Randomized inputs changing at arbitrary times.
    for (int f = 0; f < 30; f++) begin
      for (int c = 0; c < 4 * R; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 2))
            0: ifc.number_1 = pick();
            1: ifc.number_2 = pick();
            default: ifc.sel = 1'($urandom_range(0, 1));
          endcase
        end
      end
      if (f == 12) do_reset(1);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
